alu_wide_ctrl: RTL and testbench

ALU_WIDE_CTRL -- requirements
Module: alu_wide_ctrl

---
 rtl/alu_wide_pkg.sv | 35 +++
 rtl/alu_wide_ctrl.sv | 142 ++++++++++++++
 tb/tb_alu_wide_ctrl.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/alu_wide_pkg.sv
// Shared encodings for the wide-operand ALU sequencer: command ops, ALU opcodes, FSM states.
// No logic; latency and backpressure are properties of alu_wide_ctrl.
// Consumers import with alu_wide_pkg::*.
package alu_wide_pkg;

    localparam logic [2:0] OP_WADD = 3'd0;
    localparam logic [2:0] OP_WSUB = 3'd1;
    localparam logic [2:0] OP_WAND = 3'd2;
    localparam logic [2:0] OP_WNOT = 3'd3;

    localparam logic [3:0] ALU_NOP       = 4'd0;
    localparam logic [3:0] ALU_ADD_CARRY = 4'd2;
    localparam logic [3:0] ALU_AND       = 4'd6;
    localparam logic [3:0] ALU_NOT       = 4'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic logic op_legal(input logic [2:0] op);
        return (op[2] == 1'b0);
    endfunction

    function automatic logic [3:0] alu_opcode_of(input logic [2:0] op);
        case (op)
            OP_WADD, OP_WSUB: return ALU_ADD_CARRY;
            OP_WAND:          return ALU_AND;
            OP_WNOT:          return ALU_NOT;
            default:          return ALU_NOP;
        endcase
    endfunction

endpackage

// File: rtl/alu_wide_ctrl.sv
// Sequences a wide add/sub/and/not through a B_W-bit ALU one slice per cycle, LS slice first.
// Latency: N_WORDS+1 cycles from command transfer to res_valid (1 cycle for an illegal op).
// Backpressure: cmd_ready only in IDLE; result held in DONE until res_ready. ALU_WIDE_PARITY_EN adds res_parity.
module alu_wide_ctrl
    import alu_wide_pkg::*;
#(
    parameter int B_W     = 8,
    parameter int N_WORDS = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [2:0]             cmd_op,
    input  logic [N_WORDS*B_W-1:0] cmd_a,
    input  logic [N_WORDS*B_W-1:0] cmd_b,
    output logic [B_W-1:0]         alu_a,
    output logic [B_W-1:0]         alu_b,
    output logic                   alu_c_in,
    output logic [3:0]             alu_opcode,
    input  logic [B_W-1:0]         alu_y,
    input  logic                   alu_c_out,
    input  logic                   alu_invalid_op,
    input  logic                   alu_zero,
    input  logic                   alu_parity,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [N_WORDS*B_W-1:0] res_y,
    output logic                   res_carry,
    output logic                   res_zero,
    output logic                   res_err,
    output logic                   res_parity
);

    localparam int             W      = N_WORDS * B_W;
    localparam int             K_W    = $clog2(N_WORDS);
    localparam logic [K_W-1:0] K_LAST = K_W'(N_WORDS - 1);

    state_e         state, state_nxt;
    logic [2:0]     op_q;
    logic [W-1:0]   a_q, b_q, y_q;
    logic [K_W-1:0] k_q;
    logic           c_q, carry_q, zero_q, err_q;
    logic           take, in_run, last;

    assign take   = cmd_valid && cmd_ready;
    assign in_run = (state == ST_RUN);
    assign last   = in_run && (k_q == K_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        cmd_ready  = 1'b0;
        res_valid  = 1'b0;
        alu_a      = '0;
        alu_b      = '0;
        alu_c_in   = 1'b0;
        alu_opcode = ALU_NOP;
        case (state)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) state_nxt = op_legal(cmd_op) ? ST_RUN : ST_DONE;
            end
            ST_RUN: begin
                alu_a      = a_q[k_q*B_W +: B_W];
                // Subtraction is A + ~B + 1: invert B here, inject the +1 as slice-0 carry.
                alu_b      = b_q[k_q*B_W +: B_W] ^ {B_W{op_q == OP_WSUB}};
                alu_opcode = alu_opcode_of(op_q);
                if (op_q == OP_WADD || op_q == OP_WSUB)
                    alu_c_in = (k_q == '0) ? (op_q == OP_WSUB) : c_q;
                if (last) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                res_valid = 1'b1;
                if (res_ready) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            y_q     <= '0;
            k_q     <= '0;
            c_q     <= 1'b0;
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
            err_q   <= 1'b0;
        end else if (take) begin
            op_q    <= cmd_op;
            a_q     <= cmd_a;
            b_q     <= cmd_b;
            y_q     <= '0;
            k_q     <= '0;
            c_q     <= 1'b0;
            carry_q <= 1'b0;
            zero_q  <= op_legal(cmd_op);
            err_q   <= !op_legal(cmd_op);
        end else if (in_run) begin
            y_q[k_q*B_W +: B_W] <= alu_y;
            k_q    <= k_q + 1'b1;
            c_q    <= alu_c_out;
            zero_q <= zero_q & alu_zero;
            err_q  <= err_q | alu_invalid_op;
            if (last) begin
                if (op_q == OP_WADD)      carry_q <= alu_c_out;
                else if (op_q == OP_WSUB) carry_q <= ~alu_c_out;
                else                      carry_q <= 1'b0;
            end
        end
    end

`ifdef ALU_WIDE_PARITY_EN
    logic parity_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      parity_q <= 1'b0;
        else if (take)   parity_q <= 1'b0;
        else if (in_run) parity_q <= parity_q ^ alu_parity;
    end

    assign res_parity = parity_q;
`else
    // ALU parity is deliberately ignored in this build.
    logic unused_parity;
    assign unused_parity = alu_parity;
    assign res_parity    = 1'b0;
`endif

    assign res_y     = y_q;
    assign res_carry = carry_q;
    assign res_zero  = zero_q;
    assign res_err   = err_q;

endmodule

// File: tb/tb_alu_wide_ctrl.sv
// Directed bench for alu_wide_ctrl with a behavioural slice ALU on the alu_* port.
module tb_alu_wide_ctrl;

    localparam int B_W     = 8;
    localparam int N_WORDS = 4;
    localparam int W       = N_WORDS * B_W;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           cmd_valid, cmd_ready;
    logic [2:0]     cmd_op;
    logic [W-1:0]   cmd_a, cmd_b;
    logic [B_W-1:0] alu_a, alu_b, alu_y;
    logic           alu_c_in, alu_c_out, alu_invalid_op, alu_zero, alu_parity;
    logic [3:0]     alu_opcode;
    logic           res_valid, res_ready;
    logic [W-1:0]   res_y;
    logic           res_carry, res_zero, res_err, res_parity;
    logic           inj_inv = 1'b0;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         inj;
        logic [W-1:0] y;
        logic         carry;
        logic         zero;
        logic         err;
    } vec_t;

    vec_t vecs[11];

    always #5 clk = ~clk;

    alu_wide_ctrl #(.B_W(B_W), .N_WORDS(N_WORDS)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_a(cmd_a), .cmd_b(cmd_b),
        .alu_a(alu_a), .alu_b(alu_b), .alu_c_in(alu_c_in), .alu_opcode(alu_opcode),
        .alu_y(alu_y), .alu_c_out(alu_c_out), .alu_invalid_op(alu_invalid_op),
        .alu_zero(alu_zero), .alu_parity(alu_parity),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_y(res_y), .res_carry(res_carry), .res_zero(res_zero),
        .res_err(res_err), .res_parity(res_parity)
    );

    // Behavioural slice ALU: 2=add with carry, 6=and, 7=not, anything else invalid.
    always_comb begin
        {alu_c_out, alu_y} = '0;
        case (alu_opcode)
            4'd2:    {alu_c_out, alu_y} = {1'b0, alu_a} + {1'b0, alu_b} + {{B_W{1'b0}}, alu_c_in};
            4'd6:    alu_y = alu_a & alu_b;
            4'd7:    alu_y = ~alu_a;
            default: ;
        endcase
        alu_invalid_op = !(alu_opcode == 4'd2 || alu_opcode == 4'd6 || alu_opcode == 4'd7) || inj_inv;
        alu_zero       = (alu_y == '0);
        alu_parity     = ^alu_y;
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    function automatic logic [3:0] exp_opc(input logic [2:0] op);
        case (op)
            3'd0, 3'd1: return 4'd2;
            3'd2:       return 4'd6;
            3'd3:       return 4'd7;
            default:    return 4'd0;
        endcase
    endfunction

    task automatic run_vec(input vec_t v, input int hold);
        int   cyc;
        logic legal;
        logic exp_par;
        legal = (v.op < 3'd4);
`ifdef ALU_WIDE_PARITY_EN
        exp_par = ^v.y;
`else
        exp_par = 1'b0;
`endif
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = v.op; cmd_a = v.a; cmd_b = v.b; res_ready = 1'b0;
        #1 check("cmd_ready_idle", cmd_ready, 1);
        @(posedge clk); #1;
        // Scramble inputs: they must be ignored while busy.
        cmd_valid = 1'b0; cmd_op = 3'd3; cmd_a = ~v.a; cmd_b = ~v.b;
        cyc = 1;
        check("opcode_first", alu_opcode, exp_opc(v.op));
        check("c_in_first", alu_c_in, (v.op == 3'd1));
        while (!res_valid && cyc < 20) begin
            if (cmd_ready) check("cmd_ready_busy", cmd_ready, 0);
            @(posedge clk); #1;
            cyc++;
        end
        check("latency", cyc, legal ? N_WORDS + 1 : 1);
        check("res_y", res_y, v.y);
        check("res_carry", res_carry, v.carry);
        check("res_zero", res_zero, v.zero);
        check("res_err", res_err, v.err);
        check("res_parity", res_parity, exp_par);
        check("done_opcode", alu_opcode, 0);
        for (int h = 0; h < hold; h++) begin
            cmd_valid = 1'b1; cmd_op = 3'd0; cmd_a = 32'h1; cmd_b = 32'h1;
            @(posedge clk); #1;
            check("hold_valid", res_valid, 1);
            check("hold_res_y", res_y, v.y);
            check("hold_cmd_ready", cmd_ready, 0);
        end
        cmd_valid = 1'b0; res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        check("post_hs_valid", res_valid, 0);
        check("post_hs_ready", cmd_ready, 1);
    endtask

    initial begin
        int   cyc;
        logic seen;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0; res_ready = 1'b0;

        vecs[0]  = '{3'd0, 32'h00FFFFFF, 32'h00000001, 1'b0, 32'h01000000, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{3'd0, 32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b0};
        vecs[2]  = '{3'd1, 32'h00000000, 32'h00000001, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{3'd1, 32'h12345678, 32'h00000078, 1'b0, 32'h12345600, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{3'd2, 32'hF0F0F0F0, 32'hFF00FF00, 1'b0, 32'hF000F000, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{3'd3, 32'hA5A5A5A5, 32'h12345678, 1'b0, 32'h5A5A5A5A, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{3'd2, 32'h0F0F0F0F, 32'hF0F0F0F0, 1'b0, 32'h00000000, 1'b0, 1'b1, 1'b0};
        vecs[7]  = '{3'd5, 32'hDEADBEEF, 32'h01234567, 1'b0, 32'h00000000, 1'b0, 1'b0, 1'b1};
        vecs[8]  = '{3'd1, 32'h00000005, 32'h00000005, 1'b0, 32'h00000000, 1'b0, 1'b1, 1'b0};
        vecs[9]  = '{3'd0, 32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b0};
        vecs[10] = '{3'd0, 32'h00000001, 32'h00000002, 1'b1, 32'h00000003, 1'b0, 1'b0, 1'b1};

        #12;
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_y", res_y, 0);
        check("rst_flags", {res_carry, res_zero, res_err, res_parity}, 0);
        check("rst_alu", {alu_opcode, alu_c_in, alu_a, alu_b}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 11; i++) begin
            inj_inv = vecs[i].inj;
            run_vec(vecs[i], (i == 4) ? 3 : (i == 7 ? 1 : 0));
            inj_inv = 1'b0;
        end

        // Abort in RUN slice k=2.
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 3'd0; cmd_a = 32'h11223344; cmd_b = 32'h00000001;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("abort_k2_alu_a", alu_a, 8'h22);
        rst_n = 1'b0;
        #1;
        check("abort_cmd_ready", cmd_ready, 1);
        check("abort_res_valid", res_valid, 0);
        check("abort_alu", {alu_opcode, alu_c_in, alu_a, alu_b}, 0);
        check("abort_res_y", res_y, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (cyc = 0; cyc < 8; cyc++) begin
            @(posedge clk); #1;
            if (res_valid) seen = 1'b1;
        end
        check("abort_no_valid", seen, 0);
        run_vec(vecs[0], 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
